// File: rtl/cas_tape_player.sv
// Cassette playback: streams a CAS image from SDRAM and emits CoCo FSK audio,
// one square cycle per bit (short cycle = '1', long cycle = '0'), LSB first.
module cas_tape_player #(
  parameter int HALF_1 = 11932,
  parameter int HALF_0 = 23863,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        play,
  input  logic        rewind,
  input  logic        motor,
  input  logic        tape_load,
  input  logic [24:0] tape_size,
  output logic [24:0] sdram_addr,
  output logic        sdram_rd,
  input  logic [7:0]  sdram_data,
  output logic        data,
  output logic        active,
  output logic        eot
);

  localparam int HC_W = $clog2(HALF_0);
  localparam logic [HC_W-1:0] H1_LAST = HC_W'(HALF_1 - 1);
  localparam logic [HC_W-1:0] H0_LAST = HC_W'(HALF_0 - 1);

  typedef enum logic [2:0] {IDLE, FETCH0, WAIT0, BIT, STALL, DONE} state_t;

  state_t            state;
  logic              running;
  logic [7:0]        shifter;
  logic [7:0]        pf_buf;
  logic              pf_valid;
  logic              pf_req;
  logic [2:0]        bitcnt;
  logic              half;
  logic [HC_W-1:0]   halfcnt;
  logic [24:0]       cur_addr;
  logic [RD_LAT-1:0] rd_pipe;

  logic              run;
  logic [HC_W-1:0]   half_last;
  logic [24:0]       addr_p1;
  logic [24:0]       addr_p2;

  assign run       = running & motor;
  assign half_last = shifter[0] ? H1_LAST : H0_LAST;
  assign addr_p1   = cur_addr + 25'd1;
  assign addr_p2   = cur_addr + 25'd2;

  // All SDRAM reads land in pf_buf; rd_pipe marks the cycle the data is valid.
  always_ff @(posedge clk) begin
    if (reset || rewind || tape_load) begin
      state      <= IDLE;
      running    <= 1'b0;
      shifter    <= 8'd0;
      pf_buf     <= 8'd0;
      pf_valid   <= 1'b0;
      pf_req     <= 1'b0;
      bitcnt     <= 3'd0;
      half       <= 1'b0;
      halfcnt    <= '0;
      cur_addr   <= 25'd0;
      rd_pipe    <= '0;
      sdram_addr <= 25'd0;
      sdram_rd   <= 1'b0;
      data       <= 1'b0;
      active     <= 1'b0;
      eot        <= 1'b0;
    end else begin
      sdram_rd   <= 1'b0;
      sdram_addr <= cur_addr;
      active     <= running & motor & (state != IDLE) & ~eot;
      rd_pipe[0] <= sdram_rd;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];

      if (pf_req) begin
        sdram_rd   <= 1'b1;
        sdram_addr <= addr_p1;
        pf_req     <= 1'b0;
      end

      if (play && (state inside {FETCH0, WAIT0, BIT, STALL})) running <= ~running;

      case (state)
        IDLE: begin
          if (play && tape_size != 25'd0) begin
            running <= 1'b1;
            state   <= FETCH0;
          end
        end
        FETCH0: begin
          if (run) begin
            sdram_rd   <= 1'b1;
            sdram_addr <= cur_addr;
            state      <= WAIT0;
          end
        end
        WAIT0: begin
          if (run && pf_valid) begin
            shifter  <= pf_buf;
            pf_valid <= 1'b0;
            bitcnt   <= 3'd0;
            half     <= 1'b0;
            halfcnt  <= '0;
            data     <= 1'b1;
            state    <= BIT;
            if (addr_p1 < tape_size) begin
              sdram_rd   <= 1'b1;
              sdram_addr <= addr_p1;
            end
          end
        end
        BIT: begin
          if (run) begin
            if (halfcnt == half_last) begin
              halfcnt <= '0;
              if (!half) begin
                half <= 1'b1;
                data <= 1'b0;
              end else begin
                half   <= 1'b0;
                bitcnt <= bitcnt + 3'd1;
                if (bitcnt != 3'd7) begin
                  shifter <= {1'b0, shifter[7:1]};
                  data    <= 1'b1;
                end else if (addr_p1 == tape_size) begin
                  state   <= DONE;
                  data    <= 1'b0;
                  eot     <= 1'b1;
                  running <= 1'b0;
                  active  <= 1'b0;
                end else if (pf_valid) begin
                  // Next byte starts on the very next cycle, no gap.
                  shifter    <= pf_buf;
                  pf_valid   <= 1'b0;
                  cur_addr   <= addr_p1;
                  sdram_addr <= addr_p1;
                  data       <= 1'b1;
                  pf_req     <= (addr_p2 < tape_size);
                end else begin
                  data  <= 1'b0;
                  state <= STALL;
                end
              end
            end else begin
              halfcnt <= halfcnt + HC_W'(1);
            end
          end
        end
        STALL: begin
          if (run && pf_valid) begin
            shifter    <= pf_buf;
            pf_valid   <= 1'b0;
            cur_addr   <= addr_p1;
            sdram_addr <= addr_p1;
            data       <= 1'b1;
            pf_req     <= (addr_p2 < tape_size);
            state      <= BIT;
          end
        end
        DONE: begin
        end
        default: state <= IDLE;
      endcase

      if (rd_pipe[RD_LAT-1]) begin
        pf_buf   <= sdram_data;
        pf_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cas_tape_player.sv
// Randomized scoreboard bench for cas_tape_player: expected high/low run lengths are
// queued from the tape bytes and compared by a monitor that measures the waveform.
module tb_cas_tape_player;

  localparam int H1  = 4;
  localparam int H0  = 8;
  localparam int PER = 10;

  logic        clk = 1'b0;
  logic        reset, play, rewind, motor, tape_load;
  logic [24:0] tape_size;
  logic [24:0] sdram_addr;
  logic        sdram_rd;
  logic [7:0]  sdram_data;
  logic        data, active, eot;

  typedef struct {
    logic level;
    int   len;
  } seg_t;

  seg_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;
  logic [7:0]  tape_mem [0:3];
  logic        rp0 = 1'b0, rp1 = 1'b0;
  logic [24:0] ra0 = 25'd0, ra1 = 25'd0;
  int          rd_count = 0;

  always #(PER/2) clk = ~clk;

  cas_tape_player #(.HALF_1(H1), .HALF_0(H0), .RD_LAT(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .play       (play),
    .rewind     (rewind),
    .motor      (motor),
    .tape_load  (tape_load),
    .tape_size  (tape_size),
    .sdram_addr (sdram_addr),
    .sdram_rd   (sdram_rd),
    .sdram_data (sdram_data),
    .data       (data),
    .active     (active),
    .eot        (eot)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // SDRAM model: data valid two cycles after the read strobe.
  assign sdram_data = rp1 ? tape_mem[ra1[1:0]] : 8'h3C;

  always @(posedge clk) begin
    rp0 <= sdram_rd;
    ra0 <= sdram_addr;
    rp1 <= rp0;
    ra1 <= ra0;
    if (sdram_rd) begin
      rd_count <= rd_count + 1;
      checkOutput("rd_addr_range", int'(sdram_addr < tape_size), 1);
    end
  end

  // Monitor: measure every high/low run of data and compare with the queue.
  logic run_active = 1'b0;
  logic run_level  = 1'b0;
  int   run_len    = 0;

  task automatic closeRun();
    seg_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL seg_extra actual level %0d len %0d expected no segment", run_level, run_len);
    end else begin
      e = sb_q.pop_front();
      checkOutput("seg_level", run_level, e.level);
      checkOutput("seg_len", run_len, e.len);
    end
  endtask

  always @(negedge clk) begin
    if (!mon_en) begin
      run_active = 1'b0;
    end else if (!run_active) begin
      if (data && !eot) begin
        run_active = 1'b1;
        run_level  = 1'b1;
        run_len    = 1;
      end
    end else if (eot || data != run_level) begin
      closeRun();
      if (eot) run_active = 1'b0;
      else begin
        run_level = data;
        run_len   = 1;
      end
    end else begin
      run_len++;
    end
  end

  // Reference: each bit is a high half then a low half; a freeze stretches the
  // run containing stream position fpos by flen cycles.
  function automatic int pushExpected(input int nbytes, input int fpos, input int flen);
    int   pos = 0;
    int   h;
    seg_t s;
    for (int b = 0; b < nbytes; b++) begin
      for (int i = 0; i < 8; i++) begin
        h = tape_mem[b][i] ? H1 : H0;
        for (int lv = 1; lv >= 0; lv--) begin
          s.level = lv[0];
          s.len   = h;
          if (fpos >= pos && fpos < pos + h) s.len += flen;
          sb_q.push_back(s);
          pos += h;
        end
      end
    end
    return pos + ((fpos >= 0) ? flen : 0);
  endfunction

  task automatic pulsePlay();
    @(posedge clk); #1 play = 1'b1;
    @(posedge clk); #1 play = 1'b0;
  endtask

  task automatic pulseRewind(input bit use_load);
    @(posedge clk); #1;
    if (use_load) tape_load = 1'b1;
    else rewind = 1'b1;
    @(posedge clk);
    if (use_load) @(posedge clk);
    #1 rewind = 1'b0;
    tape_load = 1'b0;
  endtask

  task automatic waitRise(output bit ok, output time ts);
    ok = 1'b0;
    ts = $time;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (data) begin
        ok = 1'b1;
        ts = $time;
        break;
      end
    end
    checkOutput("stream_start", data, 1);
  endtask

  // Play a whole tape: mode 0 plain, 1 pause via play, 2 motor off; optional address probes.
  task automatic applyStimulus(input int nbytes, input int mode, input int p, input int d,
                               input bit do_rewind, input bit use_load,
                               input int probe_a, input int exp_a,
                               input int probe_b, input int exp_b);
    bit  ok;
    time ts;
    int  total;
    int  n;
    tape_size = 25'(nbytes);
    motor     = 1'b1;
    if (do_rewind) begin
      pulseRewind(use_load);
      @(negedge clk);
      checkOutput("eot_cleared", eot, 0);
    end
    sb_q.delete();
    total  = pushExpected(nbytes, (mode == 0) ? -1 : p + 1, d);
    mon_en = 1'b1;
    pulsePlay();
    waitRise(ok, ts);
    if (ok) begin
      checkOutput("active_run", active, 1);
      if (mode == 1) begin
        repeat (p) @(posedge clk);
        #1 play = 1'b1;
        @(posedge clk); #1 play = 1'b0;
        repeat (d - 1) @(posedge clk);
        #1 play = 1'b1;
        @(posedge clk); #1 play = 1'b0;
      end else if (mode == 2) begin
        repeat (p + 1) @(posedge clk);
        #1 motor = 1'b0;
        repeat (d) @(posedge clk);
        #1 motor = 1'b1;
      end else begin
        if (probe_a > 0) begin
          repeat (probe_a) @(negedge clk);
          checkOutput("addr_probe_a", int'(sdram_addr), exp_a);
        end
        if (probe_b > probe_a) begin
          repeat (probe_b - probe_a) @(negedge clk);
          checkOutput("addr_probe_b", int'(sdram_addr), exp_b);
        end
      end
    end
    for (int i = 0; i < 4000; i++) begin
      if (eot) break;
      @(negedge clk);
    end
    checkOutput("eot_set", eot, 1);
    n = int'(($time - ts) / PER);
    checkOutput("stream_len", n, total);
    repeat (2) @(negedge clk);
    checkOutput("eot_hold", eot, 1);
    checkOutput("active_end", active, 0);
    checkOutput("data_end", data, 0);
    checkOutput("sb_empty", sb_q.size(), 0);
    mon_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit  ok;
    time ts;
    int  cnt;
    int  nb;
    reset = 1'b1; play = 1'b0; rewind = 1'b0; motor = 1'b1; tape_load = 1'b0;
    tape_size = 25'd0;
    for (int i = 0; i < 4; i++) tape_mem[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_data", data, 0);
    checkOutput("rst_rd", sdram_rd, 0);
    checkOutput("rst_addr", int'(sdram_addr), 0);
    checkOutput("rst_active", active, 0);
    checkOutput("rst_eot", eot, 0);

    $display("[TB] single byte 0xA5");
    tape_mem[0] = 8'hA5;
    applyStimulus(1, 0, 0, 0, 1'b0, 1'b0, -1, 0, -1, 0);

    $display("[TB] two bytes back to back");
    tape_mem[0] = 8'h00;
    tape_mem[1] = 8'hFF;
    applyStimulus(2, 0, 0, 0, 1'b1, 1'b0, 50, 0, 148, 1);

    $display("[TB] pause via play and via motor");
    tape_mem[0] = 8'hA5;
    applyStimulus(1, 1, 10, 20, 1'b1, 1'b0, -1, 0, -1, 0);
    applyStimulus(1, 2, 10, 20, 1'b1, 1'b0, -1, 0, -1, 0);

    $display("[TB] rewind mid byte 1");
    tape_mem[1] = 8'h3C;
    tape_size   = 25'd2;
    pulseRewind(1'b0);
    pulsePlay();
    waitRise(ok, ts);
    repeat (116) @(posedge clk);
    #1 rewind = 1'b1;
    @(posedge clk); #1 rewind = 1'b0;
    checkOutput("rew_addr", int'(sdram_addr), 0);
    checkOutput("rew_data", data, 0);
    checkOutput("rew_active", active, 0);
    checkOutput("rew_eot", eot, 0);
    applyStimulus(2, 0, 0, 0, 1'b0, 1'b0, -1, 0, -1, 0);

    $display("[TB] play and rewind together, play with empty tape");
    tape_size = 25'd1;
    pulseRewind(1'b0);
    pulsePlay();
    waitRise(ok, ts);
    repeat (20) @(posedge clk);
    #1 play = 1'b1;
    rewind = 1'b1;
    @(posedge clk); #1 play = 1'b0;
    rewind = 1'b0;
    checkOutput("pr_addr", int'(sdram_addr), 0);
    checkOutput("pr_data", data, 0);
    repeat (20) @(negedge clk);
    checkOutput("pr_data_idle", data, 0);
    checkOutput("pr_active_idle", active, 0);
    applyStimulus(1, 0, 0, 0, 1'b0, 1'b0, -1, 0, -1, 0);
    pulseRewind(1'b0);
    tape_size = 25'd0;
    cnt = rd_count;
    pulsePlay();
    repeat (20) @(negedge clk);
    checkOutput("size0_active", active, 0);
    checkOutput("size0_reads", rd_count - cnt, 0);
    checkOutput("size0_data", data, 0);

    $display("[TB] randomized tapes");
    for (int it = 0; it < 6; it++) begin
      nb = $urandom_range(1, 3);
      for (int b = 0; b < 4; b++) tape_mem[b] = 8'($urandom);
      applyStimulus(nb, $urandom_range(0, 2), $urandom_range(2, 60), $urandom_range(1, 25),
                    1'b1, it[0], -1, 0, -1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
